rtc_calendar: RTL and testbench

RTC_CALENDAR -- requirements
Module: rtc_calendar

---
 rtl/rtc_pkg.sv | 54 +++++
 rtl/rtc_bcd_cnt.sv | 43 ++++
 rtl/rtc_calendar.sv | 117 +++++++++++
 tb/tb_rtc_calendar.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types, field offsets and calendar helpers for the BCD real-time clock.
package rtc_pkg;

   // Packed BCD time, most significant field first (YY MM DD hh mm ss).
   typedef struct packed {
      logic [7:0] yy;
      logic [7:0] mo;
      logic [7:0] dd;
      logic [7:0] hh;
      logic [7:0] mi;
      logic [7:0] ss;
   } rtc_time_t;

   localparam int unsigned SS_OFS = 0;
   localparam int unsigned MI_OFS = 8;
   localparam int unsigned HH_OFS = 16;
   localparam int unsigned DD_OFS = 24;
   localparam int unsigned MO_OFS = 32;
   localparam int unsigned YY_OFS = 40;

   // 10*tens + units is divisible by 4 exactly when 2*tens + units is.
   function automatic logic is_leap(input logic [7:0] yy);
      logic [4:0] s;
      s = {yy[7:4], 1'b0} + {1'b0, yy[3:0]};
      return (s[1:0] == 2'b00);
   endfunction

   // Last day of the month, in BCD; unknown months fall back to 31.
   function automatic logic [7:0] days_in_month(input logic [7:0] mo, input logic [7:0] yy);
      logic [7:0] dim;
      case (mo)
         8'h02:                     dim = is_leap(yy) ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
         default:                   dim = 8'h31;
      endcase
      return dim;
   endfunction

   // Range checks compare BCD as binary, which is order-preserving once every nibble is <= 9.
   function automatic logic bcd_valid(input rtc_time_t t);
      logic        ok;
      logic [47:0] v;
      v  = t;
      ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
      end
      if (t.ss > 8'h59 || t.mi > 8'h59 || t.hh > 8'h23) ok = 1'b0;
      if (t.mo < 8'h01 || t.mo > 8'h12) ok = 1'b0;
      if (t.dd < 8'h01 || t.dd > days_in_month(t.mo, t.yy)) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/rtc_bcd_cnt.sv
// Two-digit BCD counter with run-time wrap limit, 00/01 floor, carry chain and parallel load.
module rtc_bcd_cnt #(
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] max_val,
   input  logic       min_one,
   input  logic       cin,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       cout
);

   logic [7:0] value_q, value_d;

   assign value = value_q;
   assign cout  = cin && (value_q == max_val);

   // Next value: load wins, otherwise wrap to the floor or BCD-increment on carry-in.
   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (cin) begin
         if (value_q == max_val) begin
            value_d = {7'd0, min_one};
         end else if (value_q[3:0] == 4'd9) begin
            value_d = {value_q[7:4] + 4'd1, 4'd0};
         end else begin
            value_d = {value_q[7:4], value_q[3:0] + 4'd1};
         end
      end
   end

   // Field register.
   always_ff @(posedge clk) begin
      if (rst) value_q <= RST_VAL;
      else     value_q <= value_d;
   end

endmodule

// File: rtl/rtc_calendar.sv
// BCD calendar clock: prescaler, cascaded field counters, guarded load port.
// Optional alarm compare and sticky interrupt are built when RTC_ALARM_EN is defined.
module rtc_calendar
   import rtc_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 27_000_000,
   parameter logic [47:0] START_TIME = 48'h23_01_01_12_00_00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        set_valid,
   input  logic [47:0] set_time,
   output logic        set_ready,
   output logic        set_err,
   input  logic        alarm_wr,
   input  logic [23:0] alarm_time,
   input  logic        alarm_clr,
   output logic        alarm_irq,
   output logic        sec_pulse,
   output logic [47:0] time_num
);

   localparam int unsigned   PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] TC      = PW'(CLK_HZ - 1);
   // Day and month fields count from 01; the others from 00.
   localparam logic [5:0]    MIN_ONE = 6'b011000;

   logic [PW-1:0] presc_q;
   logic          sec_pulse_q, set_err_q, set_ready_q;
   logic          tick, accept, load_ok;
   logic [6:0]    carry;
   logic [7:0]    max_v [6];
   logic [47:0]   time_q;
   logic          unused_top_carry;

   assign tick    = (presc_q == TC);
   assign accept  = set_valid && set_ready_q;
   assign load_ok = accept && bcd_valid(rtc_time_t'(set_time));
   // A valid load swallows a coincident tick.
   assign carry[0]         = tick && !load_ok;
   assign unused_top_carry = carry[6];

   assign set_ready = set_ready_q;
   assign set_err   = set_err_q;
   assign sec_pulse = sec_pulse_q;
   assign time_num  = time_q;

   // Per-field wrap limits; the day limit tracks the current month and year.
   always_comb begin
      max_v[0] = 8'h59;
      max_v[1] = 8'h59;
      max_v[2] = 8'h23;
      max_v[3] = days_in_month(time_q[MO_OFS +: 8], time_q[YY_OFS +: 8]);
      max_v[4] = 8'h12;
      max_v[5] = 8'h99;
   end

   for (genvar i = 0; i < 6; i++) begin : g_field
      rtc_bcd_cnt #(
         .RST_VAL (START_TIME[i*8 +: 8])
      ) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .max_val  (max_v[i]),
         .min_one  (MIN_ONE[i]),
         .cin      (carry[i]),
         .load     (load_ok),
         .load_val (set_time[i*8 +: 8]),
         .value    (time_q[i*8 +: 8]),
         .cout     (carry[i+1])
      );
   end

   // Prescaler, seconds strobe and load handshake status.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q     <= '0;
         sec_pulse_q <= 1'b0;
         set_err_q   <= 1'b0;
         set_ready_q <= 1'b0;
      end else begin
         presc_q     <= (load_ok || tick) ? '0 : presc_q + 1'b1;
         sec_pulse_q <= carry[0];
         set_err_q   <= accept && !load_ok;
         set_ready_q <= 1'b1;
      end
   end

`ifdef RTC_ALARM_EN
   logic [23:0] alarm_q;
   logic        upd_q, irq_q, match;

   // Only compare in the cycle after time_num was changed by a tick or load.
   assign match     = upd_q && (time_q[HH_OFS+7:SS_OFS] == alarm_q);
   assign alarm_irq = irq_q;

   // Alarm register and sticky flag; a fresh match beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_q <= 24'h00_00_00;
         upd_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         if (alarm_wr) alarm_q <= alarm_time;
         upd_q <= carry[0] || load_ok;
         if (match)          irq_q <= 1'b1;
         else if (alarm_clr) irq_q <= 1'b0;
      end
   end
`else
   logic unused_alarm;

   assign unused_alarm = ^{alarm_wr, alarm_time, alarm_clr};
   assign alarm_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_calendar.sv
// Scoreboard bench for rtc_calendar at CLK_HZ=4; alarm checks follow RTC_ALARM_EN.
module tb_rtc_calendar;

   localparam int unsigned CLK_HZ = 4;
   localparam logic [47:0] START  = 48'h23_01_01_12_00_00;
`ifdef RTC_ALARM_EN
   localparam logic        ALARM  = 1'b1;
`else
   localparam logic        ALARM  = 1'b0;
`endif

   typedef struct {
      bit          is_err;
      logic [47:0] t;
      int          cyc;
   } exp_t;

   logic        clk, rst, set_valid, set_ready, set_err;
   logic        alarm_wr, alarm_clr, alarm_irq, sec_pulse;
   logic [47:0] set_time, time_num;
   logic [23:0] alarm_time;

   exp_t q[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   rtc_calendar #(
      .CLK_HZ     (CLK_HZ),
      .START_TIME (START)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .set_valid  (set_valid),
      .set_time   (set_time),
      .set_ready  (set_ready),
      .set_err    (set_err),
      .alarm_wr   (alarm_wr),
      .alarm_time (alarm_time),
      .alarm_clr  (alarm_clr),
      .alarm_irq  (alarm_irq),
      .sec_pulse  (sec_pulse),
      .time_num   (time_num)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input bit is_err, input logic [47:0] t, input int c);
      exp_t e;
      e.is_err = is_err;
      e.t      = t;
      e.cyc    = c;
      q.push_back(e);
   endtask

   // Every sec_pulse / set_err must match the next queued expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && (sec_pulse !== 1'b0 || set_err !== 1'b0)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got sec_pulse=%b set_err=%b time=%h at cycle %0d, required none",
                     sec_pulse, set_err, time_num, cyc);
         end else begin
            mon_e = q.pop_front();
            check("pulse_kind", {46'd0, set_err, sec_pulse}, mon_e.is_err ? 48'd2 : 48'd1);
            check("pulse_time", time_num, mon_e.t);
            check("pulse_cycle", 48'(cyc), 48'(mon_e.cyc));
         end
      end
   end

   // Accepted on the second posedge; returns 1 time unit after it.
   task automatic load(input logic [47:0] t);
      @(posedge clk);
      #1 set_valid = 1'b1;
      set_time = t;
      @(posedge clk);
      #1 set_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending events, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic load_tick(input string name, input logic [47:0] t, input logic [47:0] nxt);
      load(t);
      check({name, "_load"}, time_num, t);
      push(1'b0, nxt, cyc + 4);
      drain(12);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst = 1'b1; set_valid = 1'b0; set_time = '0;
      alarm_wr = 1'b0; alarm_time = '0; alarm_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_time", time_num, START);
      check("rst_ready", {47'd0, set_ready}, 48'd0);
      check("rst_pulse", {47'd0, sec_pulse}, 48'd0);
      check("rst_err", {47'd0, set_err}, 48'd0);
      check("rst_irq", {47'd0, alarm_irq}, 48'd0);

      // Run from reset with alarm 12:00:05.
      @(posedge clk);
      #1 rst = 1'b0;
      alarm_wr = 1'b1;
      alarm_time = 24'h12_00_05;
      c0 = cyc;
      for (int k = 1; k <= 5; k++) push(1'b0, START + 48'(k), c0 + 4 * k);
      @(posedge clk);
      #1 alarm_wr = 1'b0;
      check("ready_after_rst", {47'd0, set_ready}, 48'd1);
      repeat (18) @(posedge clk);
      #1 check("irq_before_match", {47'd0, alarm_irq}, 48'd0);
      repeat (2) @(posedge clk);
      #1 check("irq_after_match", {47'd0, alarm_irq}, {47'd0, ALARM});
      drain(2);

      // Re-match by load while clearing: match wins; then a lone clear drops it.
      load(48'h23_01_01_12_00_05);
      c0 = cyc;
      alarm_clr = 1'b1;
      @(posedge clk);
      #1 alarm_clr = 1'b0;
      check("irq_clr_vs_match", {47'd0, alarm_irq}, {47'd0, ALARM});
      alarm_clr = 1'b1;
      @(posedge clk);
      #1 alarm_clr = 1'b0;
      check("irq_cleared", {47'd0, alarm_irq}, 48'd0);
      push(1'b0, 48'h23_01_01_12_00_06, c0 + 4);
      drain(12);

      // Calendar rollovers.
      load_tick("year_roll", 48'h23_12_31_23_59_59, 48'h24_01_01_00_00_00);
      load_tick("leap_feb", 48'h24_02_28_23_59_59, 48'h24_02_29_00_00_00);
      load_tick("leap_mar", 48'h24_02_29_23_59_59, 48'h24_03_01_00_00_00);
      load_tick("plain_feb", 48'h23_02_28_23_59_59, 48'h23_03_01_00_00_00);
      load_tick("mon_30", 48'h23_04_30_23_59_59, 48'h23_05_01_00_00_00);
      load_tick("century", 48'h99_12_31_23_59_59, 48'h00_01_01_00_00_00);

      // Invalid loads, with a valid reload landing on a terminal-count edge in between.
      load(48'h23_06_15_10_20_30);
      push(1'b1, 48'h23_06_15_10_20_30, cyc + 2);
      load(48'h23_04_31_00_00_00);
      check("bad_day_hold", time_num, 48'h23_06_15_10_20_30);
      load(48'h23_06_15_10_20_30);
      check("reload_no_pulse", {47'd0, sec_pulse}, 48'd0);
      push(1'b1, 48'h23_06_15_10_20_30, cyc + 2);
      load(48'h23_13_01_00_00_00);
      check("bad_month_hold", time_num, 48'h23_06_15_10_20_30);
      push(1'b0, 48'h23_06_15_10_20_31, cyc + 2);
      drain(12);

      // Load exactly on the terminal-count cycle.
      load(48'h23_07_04_08_00_00);
      repeat (2) @(posedge clk);
      load(48'h23_07_04_09_30_00);
      check("tc_load_time", time_num, 48'h23_07_04_09_30_00);
      check("tc_load_pulse", {47'd0, sec_pulse}, 48'd0);
      push(1'b0, 48'h23_07_04_09_30_01, cyc + 4);
      drain(12);

      // Reset mid-second, colliding with a load and an alarm write.
      load(48'h23_01_01_12_00_05);
      @(posedge clk);
      #1 check("irq_rematch", {47'd0, alarm_irq}, {47'd0, ALARM});
      rst = 1'b1;
      set_valid = 1'b1;
      set_time = 48'h23_05_05_05_05_05;
      alarm_wr = 1'b1;
      alarm_time = 24'h05_05_05;
      @(posedge clk);
      #1 rst = 1'b0;
      set_valid = 1'b0;
      alarm_wr = 1'b0;
      check("mid_rst_time", time_num, START);
      check("mid_rst_pulse", {47'd0, sec_pulse}, 48'd0);
      check("mid_rst_err", {47'd0, set_err}, 48'd0);
      check("mid_rst_ready", {47'd0, set_ready}, 48'd0);
      check("mid_rst_irq", {47'd0, alarm_irq}, 48'd0);
      push(1'b0, 48'h23_01_01_12_00_01, cyc + 4);
      drain(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
